axi_aw_ring_scheduler: RTL and testbench

Parametrised AXI4 write-address and write-response controller for the DDR FIFO write path. It supersedes the single-outstanding address channel. Each burst it issues reserves one slot of a circular DDR region, and it keeps up to MAX_OUTSTANDING bursts in flight. It counts committed (B-acknowledged) bursts for the read side and stalls when the ring is full. It sits between the ingress FIFO threshold logic and the AXI interconnect, and drives the W-channel burst generator through `start_single_burst_write`.

---
 rtl/axi_aw_ring_scheduler.sv | 176 +++++++++++++++++
 tb/tb_axi_aw_ring_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_aw_ring_scheduler.sv
// AXI4 write-address / write-response controller that hands out slots of a circular DDR
// region and keeps up to MAX_OUTSTANDING bursts in flight.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// AW_IDLE  | no address on the bus; issue allowed when all gates are open
// AW_START | first cycle of awvalid, start pulse to the W generator
// AW_HOLD  | awvalid held, waiting for AWREADY
module axi_aw_ring_scheduler #(
   parameter int              C_M_AXI_ADDR_WIDTH = 30,
   parameter int              C_M_AXI_DATA_WIDTH = 64,
   parameter int              C_M_AXI_BURST_LEN  = 16,
   parameter longint unsigned BASE_ADDR          = 64'd0,
   parameter int              RING_BURSTS        = 1024,
   parameter int              MAX_OUTSTANDING    = 4
) (
   input  logic                                  M_AXI_ACLK,
   input  logic                                  M_AXI_ARESET,
   input  logic                                  enable,
   input  logic                                  fifo_over_burst_thread,
   output logic                                  start_single_burst_write,
   input  logic                                  M_AXI_AWREADY,
   output logic                                  axi_awvalid,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]         axi_awaddr,
   output logic [7:0]                            axi_awlen,
   input  logic                                  M_AXI_BVALID,
   input  logic [1:0]                            M_AXI_BRESP,
   output logic                                  axi_bready,
   input  logic                                  burst_consumed,
   output logic [$clog2(RING_BURSTS):0]          bursts_committed,
   output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_cnt,
   output logic                                  ring_full,
   output logic                                  write_resp_error
);

   localparam int AW          = C_M_AXI_ADDR_WIDTH;
   localparam int BURST_BYTES = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
   localparam int SW          = (RING_BURSTS > 1) ? $clog2(RING_BURSTS) : 1;
   localparam int CW          = $clog2(RING_BURSTS) + 1;
   localparam int OW          = $clog2(MAX_OUTSTANDING) + 1;

   localparam logic [AW-1:0] BASE_A    = AW'(BASE_ADDR);
   localparam logic [AW-1:0] STEP_A    = AW'(BURST_BYTES);
   localparam logic [SW-1:0] LAST_SLOT = SW'(RING_BURSTS - 1);
   localparam logic [CW-1:0] RING_CNT  = CW'(RING_BURSTS);
   localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_OUTSTANDING);
   localparam logic [7:0]    AWLEN_C   = 8'(C_M_AXI_BURST_LEN - 1);

   typedef enum logic [1:0] {
      AW_IDLE  = 2'd0,
      AW_START = 2'd1,
      AW_HOLD  = 2'd2
   } aw_state_e;

   aw_state_e         state_q, state_d;
   logic [SW-1:0]     slot_q, slot_d;
   logic [AW-1:0]     awaddr_q, awaddr_d;
   logic [CW-1:0]     occ_q, occ_d;
   logic [CW-1:0]     comm_q, comm_d;
   logic [OW-1:0]     out_q, out_d;
   logic              bready_q, bready_d;
   logic              err_q, err_d;

   logic              issue;
   logic              aw_hs;
   logic              b_hs;
   logic              cons_ok;
   logic              full_w;
   logic              unused_bresp;

   assign unused_bresp = M_AXI_BRESP[0];

   // Every gate below looks at registered state only, so the counters can never overshoot.
   assign full_w  = (occ_q == RING_CNT);
   assign issue   = enable & fifo_over_burst_thread & (state_q == AW_IDLE) &
                    (out_q < MAX_OUT) & ~full_w;
   assign aw_hs   = (state_q != AW_IDLE) & M_AXI_AWREADY;
   assign b_hs    = M_AXI_BVALID & bready_q;
   assign cons_ok = burst_consumed & (comm_q != '0);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         AW_IDLE: begin
            if (issue) begin
               state_d = AW_START;
            end
         end
         AW_START: begin
            state_d = aw_hs ? AW_IDLE : AW_HOLD;
         end
         AW_HOLD: begin
            if (aw_hs) begin
               state_d = AW_IDLE;
            end
         end
         default: begin
            state_d = AW_IDLE;
         end
      endcase
   end

   // Slot advances on the handshake; the address register tracks it incrementally.
   always_comb begin
      slot_d   = slot_q;
      awaddr_d = awaddr_q;
      if (aw_hs) begin
         if (slot_q == LAST_SLOT) begin
            slot_d   = '0;
            awaddr_d = BASE_A;
         end else begin
            slot_d   = slot_q + SW'(1);
            awaddr_d = awaddr_q + STEP_A;
         end
      end
   end

   always_comb begin
      out_d = out_q;
      if (issue & ~b_hs) begin
         out_d = out_q + OW'(1);
      end else if (~issue & b_hs) begin
         out_d = out_q - OW'(1);
      end

      occ_d = occ_q;
      if (issue & ~cons_ok) begin
         occ_d = occ_q + CW'(1);
      end else if (~issue & cons_ok) begin
         occ_d = occ_q - CW'(1);
      end

      comm_d = comm_q;
      if (b_hs & ~cons_ok) begin
         comm_d = comm_q + CW'(1);
      end else if (~b_hs & cons_ok) begin
         comm_d = comm_q - CW'(1);
      end

      bready_d = (out_d != '0);
      err_d    = err_q | (b_hs & M_AXI_BRESP[1]);
   end

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state_q  <= AW_IDLE;
         slot_q   <= '0;
         awaddr_q <= BASE_A;
         occ_q    <= '0;
         comm_q   <= '0;
         out_q    <= '0;
         bready_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         awaddr_q <= awaddr_d;
         occ_q    <= occ_d;
         comm_q   <= comm_d;
         out_q    <= out_d;
         bready_q <= bready_d;
         err_q    <= err_d;
      end
   end

   assign start_single_burst_write = (state_q == AW_START);
   assign axi_awvalid              = (state_q != AW_IDLE);
   assign axi_awaddr               = awaddr_q;
   assign axi_awlen                = AWLEN_C;
   assign axi_bready               = bready_q;
   assign bursts_committed         = comm_q;
   assign outstanding_cnt          = out_q;
   assign ring_full                = full_w;
   assign write_resp_error         = err_q;

endmodule

// File: tb/tb_axi_aw_ring_scheduler.sv
// Directed bench for axi_aw_ring_scheduler: an occupancy/slot model checked every cycle,
// plus hand-computed expectations for latency, wrap, limits and error handling.
module tb_axi_aw_ring_scheduler;

   localparam int              AW   = 30;
   localparam int              DW   = 64;
   localparam int              BL   = 16;
   localparam int              RING = 8;
   localparam int              MAXO = 4;
   localparam longint unsigned BASE = 64'h400;
   localparam int              BB   = BL * DW / 8;
   localparam int              CW   = $clog2(RING) + 1;
   localparam int              OW   = $clog2(MAXO) + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          enable = 1'b0, fifo_thr = 1'b0, burst_consumed = 1'b0;
   logic          awready = 1'b0;
   logic          auto_bvalid = 1'b0, man_bvalid = 1'b0;
   logic [1:0]    auto_bresp = 2'b00, man_bresp = 2'b00;
   logic          b_manual = 1'b0;
   wire           bvalid = b_manual ? man_bvalid : auto_bvalid;
   wire  [1:0]    bresp  = b_manual ? man_bresp  : auto_bresp;

   logic          start, awvalid, bready, ring_full, resp_err;
   logic [AW-1:0] awaddr;
   logic [7:0]    awlen;
   logic [CW-1:0] committed;
   logic [OW-1:0] outstanding;

   axi_aw_ring_scheduler #(
      .C_M_AXI_ADDR_WIDTH (AW),
      .C_M_AXI_DATA_WIDTH (DW),
      .C_M_AXI_BURST_LEN  (BL),
      .BASE_ADDR          (BASE),
      .RING_BURSTS        (RING),
      .MAX_OUTSTANDING    (MAXO)
   ) dut (
      .M_AXI_ACLK               (clk),
      .M_AXI_ARESET             (rst),
      .enable                   (enable),
      .fifo_over_burst_thread   (fifo_thr),
      .start_single_burst_write (start),
      .M_AXI_AWREADY            (awready),
      .axi_awvalid              (awvalid),
      .axi_awaddr               (awaddr),
      .axi_awlen                (awlen),
      .M_AXI_BVALID             (bvalid),
      .M_AXI_BRESP              (bresp),
      .axi_bready               (bready),
      .burst_consumed           (burst_consumed),
      .bursts_committed         (committed),
      .outstanding_cnt          (outstanding),
      .ring_full                (ring_full),
      .write_resp_error         (resp_err)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // AXI slave: AWREADY (optionally random), B returned two cycles after each AW handshake.
   int            cyc = 0;
   int            aw_due[$];
   logic [AW-1:0] aw_log[$];
   int            rise_q[$];
   int            bhs_q[$];
   int            b_idx = 0;
   int            err_at = -1;
   int            start_cnt = 0;
   bit            b_hold = 0;
   bit            aw_stall = 0;
   logic          prev_awv = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         aw_due.delete();
         auto_bvalid = 1'b0;
         auto_bresp  = 2'b00;
         b_idx       = 0;
         prev_awv    = 1'b0;
         awready     = 1'b0;
      end else begin
         awready = aw_stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (awvalid && !prev_awv) rise_q.push_back(cyc);
         prev_awv = awvalid;
         if (start) start_cnt++;
         if (awvalid && awready) begin
            aw_due.push_back(cyc + 2);
            aw_log.push_back(awaddr);
         end
         auto_bvalid = 1'b0;
         auto_bresp  = 2'b00;
         if (!b_manual && !b_hold && aw_due.size() > 0 && aw_due[0] <= cyc) begin
            auto_bvalid = 1'b1;
            auto_bresp  = (b_idx == err_at) ? 2'b10 : 2'b00;
            if (bready) begin
               void'(aw_due.pop_front());
               b_idx++;
               bhs_q.push_back(cyc);
            end
         end
      end
   end

   // Model: occupancy / in-flight / committed counts and the ring slot as plain integers.
   int m_occ = 0, m_out = 0, m_comm = 0, m_slot = 0;
   int m_awv = 0, m_start = 0, m_bready = 0, m_err = 0;
   int i_issue, i_aw, i_b, i_cons;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_occ = 0; m_out = 0; m_comm = 0; m_slot = 0;
         m_awv = 0; m_start = 0; m_bready = 0; m_err = 0;
      end else begin
         i_issue = (enable && fifo_thr && m_awv == 0 && m_start == 0 &&
                    m_out < MAXO && m_occ < RING) ? 1 : 0;
         i_aw    = (m_awv != 0 && awready) ? 1 : 0;
         i_b     = (bvalid && m_bready != 0) ? 1 : 0;
         i_cons  = (burst_consumed && m_comm > 0) ? 1 : 0;
         m_out  += i_issue - i_b;
         m_occ  += i_issue - i_cons;
         m_comm += i_b - i_cons;
         if (i_b != 0 && bresp[1]) m_err = 1;
         if (i_aw != 0) begin
            m_slot = (m_slot + 1) % RING;
            m_awv  = 0;
         end
         if (i_issue != 0) m_awv = 1;
         m_start  = i_issue;
         m_bready = (m_out != 0) ? 1 : 0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("m_awvalid",     64'(awvalid),     64'(m_awv));
         chk("m_start",       64'(start),       64'(m_start));
         chk("m_awaddr",      64'(awaddr),      BASE + 64'(m_slot * BB));
         chk("m_awlen",       64'(awlen),       64'(BL - 1));
         chk("m_bready",      64'(bready),      64'(m_bready));
         chk("m_committed",   64'(committed),   64'(m_comm));
         chk("m_outstanding", 64'(outstanding), 64'(m_out));
         chk("m_ring_full",   64'(ring_full),   64'(m_occ == RING));
         chk("m_resp_err",    64'(resp_err),    64'(m_err));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      enable = 1'b0; fifo_thr = 1'b0; burst_consumed = 1'b0;
      man_bvalid = 1'b0; man_bresp = 2'b00; b_manual = 1'b0; b_hold = 0; aw_stall = 0;
      step(2);
      rst = 1'b0;
      aw_log.delete(); rise_q.delete(); bhs_q.delete(); start_cnt = 0;
      step(1);
   endtask

   task automatic wait_aw(input int cnt, input string name);
      int n = 0;
      while (aw_log.size() < cnt && n < 40) begin
         step(1);
         n++;
      end
      chk(name, 64'(aw_log.size() >= cnt), 64'd1);
   endtask

   initial begin
      int max_out = 0;
      int n = 0;

      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
      chk("rst_awvalid",     64'(awvalid),     64'd0);
      chk("rst_start",       64'(start),       64'd0);
      chk("rst_awaddr",      64'(awaddr),      64'h400);
      chk("rst_awlen",       64'(awlen),       64'd15);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_committed",   64'(committed),   64'd0);
      chk("rst_bready",      64'(bready),      64'd0);
      chk("rst_ring_full",   64'(ring_full),   64'd0);
      chk("rst_resp_err",    64'(resp_err),    64'd0);

      // Streaming with the read side draining everything that commits.
      burst_consumed = 1'b1; enable = 1'b1; fifo_thr = 1'b1;
      step(1);
      chk("issue_lat_awvalid", 64'(awvalid), 64'd1);
      chk("issue_lat_start",   64'(start),   64'd1);
      chk("first_addr",        64'(awaddr),  64'h400);
      step(1);
      chk("bubble_awvalid", 64'(awvalid), 64'd0);
      chk("bubble_start",   64'(start),   64'd0);
      for (int i = 0; i < 60; i++) begin
         step(1);
         if (int'(outstanding) > max_out) max_out = int'(outstanding);
      end
      chk("max_outstanding_le4", 64'(max_out <= MAXO), 64'd1);
      chk("stream_aw_count_ge9", 64'(aw_log.size() >= 9), 64'd1);
      if (aw_log.size() >= 9) begin
         chk("addr_1",    64'(aw_log[1]), 64'h480);
         chk("addr_2",    64'(aw_log[2]), 64'h500);
         chk("addr_3",    64'(aw_log[3]), 64'h580);
         chk("addr_wrap", 64'(aw_log[8]), 64'h400);
      end
      chk("start_per_awvalid", 64'(start_cnt), 64'(rise_q.size()));

      aw_stall = 1;
      step(30);
      aw_stall = 0;

      // Asynchronous reset while an address is on the bus.
      n = 0;
      while (!awvalid && n < 20) begin
         step(1);
         n++;
      end
      chk("pre_rst_awvalid", 64'(awvalid), 64'd1);
      rst = 1'b1;
      #1;
      chk("arst_awvalid",     64'(awvalid),     64'd0);
      chk("arst_start",       64'(start),       64'd0);
      chk("arst_awaddr",      64'(awaddr),      64'h400);
      chk("arst_outstanding", 64'(outstanding), 64'd0);
      chk("arst_committed",   64'(committed),   64'd0);
      chk("arst_bready",      64'(bready),      64'd0);
      enable = 1'b0; fifo_thr = 1'b0; burst_consumed = 1'b0;
      step(2);
      rst = 1'b0;
      aw_log.delete();
      step(1);

      // Fill the ring with no consumption, then free one slot.
      enable = 1'b1; fifo_thr = 1'b1;
      step(1);
      chk("post_rst_awvalid", 64'(awvalid), 64'd1);
      chk("post_rst_addr",    64'(awaddr),  64'h400);
      step(40);
      chk("full_aw_count", 64'(aw_log.size()), 64'd8);
      chk("full_flag",     64'(ring_full),     64'd1);
      chk("full_committed", 64'(committed),    64'd8);
      if (aw_log.size() >= 8) chk("full_last_addr", 64'(aw_log[7]), 64'h780);
      burst_consumed = 1'b1;
      step(1);
      burst_consumed = 1'b0;
      step(6);
      chk("refill_aw_count", 64'(aw_log.size()), 64'd9);
      if (aw_log.size() >= 9) chk("refill_wrap_addr", 64'(aw_log[8]), 64'h400);

      // B withheld: issue stops at the outstanding limit.
      do_reset();
      b_hold = 1; enable = 1'b1; fifo_thr = 1'b1;
      step(20);
      chk("hold_outstanding", 64'(outstanding),   64'd4);
      chk("hold_aw_count",    64'(aw_log.size()), 64'd4);
      chk("hold_awvalid",     64'(awvalid),       64'd0);
      rise_q.delete(); bhs_q.delete();
      b_hold = 0;
      step(8);
      chk("resume_seen", 64'(bhs_q.size() > 0 && rise_q.size() > 0), 64'd1);
      if (bhs_q.size() > 0 && rise_q.size() > 0)
         chk("b_to_awvalid_cycles", 64'(rise_q[0] - bhs_q[0]), 64'd2);

      // Issue, B and an accepted consume on the same edge.
      do_reset();
      b_manual = 1'b1; enable = 1'b1; fifo_thr = 1'b1;
      wait_aw(2, "sim_two_issued");
      fifo_thr = 1'b0;
      step(3);
      chk("sim_pre_outstanding", 64'(outstanding), 64'd2);
      man_bvalid = 1'b1; man_bresp = 2'b00;
      step(1);
      man_bvalid = 1'b0;
      step(1);
      chk("sim_pre_committed", 64'(committed), 64'd1);
      fifo_thr = 1'b1; man_bvalid = 1'b1; burst_consumed = 1'b1;
      step(1);
      fifo_thr = 1'b0; man_bvalid = 1'b0; burst_consumed = 1'b0;
      chk("sim_outstanding", 64'(outstanding), 64'd1);
      chk("sim_committed",   64'(committed),   64'd1);
      chk("sim_awvalid",     64'(awvalid),     64'd1);
      step(4);

      // SLVERR on the second burst; consume at zero committed is ignored.
      do_reset();
      err_at = 1; enable = 1'b1; fifo_thr = 1'b1;
      wait_aw(2, "err_two_issued");
      fifo_thr = 1'b0;
      n = 0;
      while (committed != CW'(2) && n < 20) begin
         step(1);
         n++;
      end
      chk("err_committed", 64'(committed), 64'd2);
      chk("err_flag",      64'(resp_err),  64'd1);
      burst_consumed = 1'b1;
      step(2);
      burst_consumed = 1'b0;
      step(1);
      chk("err_drained", 64'(committed), 64'd0);
      burst_consumed = 1'b1;
      step(1);
      burst_consumed = 1'b0;
      step(2);
      chk("ignored_consume_committed", 64'(committed), 64'd0);
      chk("ignored_consume_full",      64'(ring_full), 64'd0);
      chk("err_sticky",                64'(resp_err),  64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
